mem_access: RTL and testbench
=============================

Name: mem_access

Overview:
- Memory stage of the 5-stage CPU: the producer side of the write-back interface.
- Takes the executed instruction's address/store data and control from EX, runs a req/ack handshake with data memory, and stalls upstream while the access is pending.
- Aligns and extends load data, then presents a registered readData/addr/memToReg bundle to write-back.

Parameters:
- DATA_W, 32, data and address width.
- TIMEOUT_CYCLES, 255, WAIT cycles without ack before abort; used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- ex_valid  in  1  EX holds a valid instruction
- ex_addr  in  32  ALU result / memory address
- ex_wdata  in  32  store data
- ex_memRead  in  1  load
- ex_memWrite  in  1  store
- ex_memToReg  in  1  load result goes to register
- ex_size  in  2  access size, per mem_pkg encoding
- ex_unsigned  in  1  zero-extend loads
- stall  out  1  upstream must hold ex_* stable
- dmem_req  out  1  memory request
- dmem_we  out  1  write enable
- dmem_addr  out  32  word-aligned address ({ex_addr[31:2],2'b00})
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_ack  in  1  memory completion
- dmem_rdata  in  32  read word
- wb_valid  out  1  one-cycle pulse, bundle valid
- wb_memToReg  out  1  to write-back
- wb_readData  out  32  aligned/extended load data
- wb_addr  out  32  ALU result pass-through
- wb_err  out  1  misalignment or timeout, valid with wb_valid

Behaviour:
- FSM states:
  - IDLE: accept; dmem_req=0.
  - WAIT: dmem_req=1 with addr/we/be/wdata held stable; leave on dmem_ack.
- mem_op = ex_valid & (ex_memRead | ex_memWrite). If both read and write are set, the store wins and memRead is ignored.
- stall = (IDLE & mem_op & aligned) | (WAIT & ~dmem_ack). Stall is low in the ack cycle so upstream advances.
- Non-mem op (ex_valid, no read/write):
  - next cycle: wb_valid=1, wb_addr=ex_addr, wb_readData=0, wb_memToReg=ex_memToReg, wb_err=0.
  - no stall.
- Aligned mem op:
  - accepted in IDLE at cycle N; WAIT from N+1.
  - ack at cycle M ≥ N+1 gives wb_valid at M+1; minimum latency 2 cycles.
- Store:
  - wb_memToReg forced to 0 and wb_readData=0.
  - dmem_be: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<addr[1:0]; word = 4'hF.
  - dmem_wdata: byte replicated ×4, half replicated ×2.
- Load:
  - select lane by addr[1:0].
  - sign-extend unless ex_unsigned; word loads are unmodified.
- Misaligned (half with addr[0]=1; word with addr[1:0]≠0):
  - no dmem_req and no stall.
  - next cycle: wb_valid=1, wb_err=1, wb_readData=0, wb_memToReg=0.
- ex_size=2'b11 is treated as word.
- dmem_ack in IDLE is ignored.
- wb_* data holds its last value between pulses.
- Reset values: all outputs 0, state IDLE.
- Reset mid-WAIT: dmem_req drops after the reset edge, the in-flight transaction is abandoned, a late ack is ignored, and no wb_valid is produced.

Optional Feature:
- MEM_ACCESS_TIMEOUT_EN:
  - an 8+ bit counter clears on entering WAIT and increments each WAIT cycle without ack.
  - at TIMEOUT_CYCLES: deassert req, return to IDLE, stall low that cycle, next cycle wb_valid=1 with wb_err=1.
  - an ack in the same cycle as the timeout wins (normal completion).
- Without the macro: WAIT holds indefinitely and timeout never sets wb_err.

Decomposition:
- mem_pkg holds:
  - size enum SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - FSM state enum {IDLE, WAIT}.
  - DATA_W default.
- Sub-module load_align (combinational): dmem_rdata, offset, size, unsigned → 32-bit result. Reused by byte-enable generation tests.

Test Plan:
- Word load, addr=0x100, rdata=0xDEADBEEF, ack 3 cycles after req → stall high 4 cycles, wb_readData=0xDEADBEEF, wb_memToReg=1, wb_valid one cycle after ack.
- Signed byte load, addr=0x103, rdata=0x80FF_0000 → wb_readData=0xFFFFFF80; unsigned variant gives 0x00000080.
- Half store, addr=0x102, wdata=0x0000ABCD → dmem_be=4'b1100, dmem_wdata=0xABCDABCD, wb_memToReg=0.
- Word load at addr 0x101 → no dmem_req, no stall, next cycle wb_valid=1 and wb_err=1.
- Reset asserted during WAIT, then ack two cycles later → dmem_req=0 after the edge, no wb_valid, next load completes normally.
- With MEM_ACCESS_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack → req drops after 4 WAIT cycles, wb_err=1.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory-access stage.
// The optional abort-on-timeout feature is enabled by defining MEM_ACCESS_TIMEOUT_EN.
package mem_pkg;

   localparam int unsigned DEFAULT_DATA_W = 32;

   // Access size encoding carried from EX; 2'b11 behaves as a word.
   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10
   } size_e;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_e;

   // Natural alignment: bytes always, halves on even addresses, words on 4-byte boundaries.
   function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] offset);
      logic ok;
      case (size)
         SZ_BYTE: ok = 1'b1;
         SZ_HALF: ok = ~offset[0];
         default: ok = (offset == 2'b00);
      endcase
      return ok;
   endfunction

   function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] offset);
      logic [3:0] be;
      case (size)
         SZ_BYTE: be = 4'b0001 << offset;
         SZ_HALF: be = 4'b0011 << offset;
         default: be = 4'hF;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load-data lane select and sign/zero extension.
module load_align
   import mem_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  offset,
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   output logic [31:0] result
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   // Pick the addressed lane and extend it to a full word.
   always_comb begin
      lane_b = 8'(rdata >> {offset, 3'b000});
      lane_h = offset[1] ? rdata[31:16] : rdata[15:0];
      case (size)
         SZ_BYTE: result = {{24{lane_b[7] & ~is_unsigned}}, lane_b};
         SZ_HALF: result = {{16{lane_h[15] & ~is_unsigned}}, lane_h};
         default: result = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// Memory stage: drives the data-memory req/ack handshake, stalls EX while an access is
// outstanding, and hands a registered result bundle to write-back.
// Optional feature: define MEM_ACCESS_TIMEOUT_EN to abort a WAIT after TIMEOUT_CYCLES.
module mem_access
   import mem_pkg::*;
#(
   parameter int unsigned DATA_W         = DEFAULT_DATA_W,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ex_valid,
   input  logic [DATA_W-1:0]   ex_addr,
   input  logic [DATA_W-1:0]   ex_wdata,
   input  logic                ex_memRead,
   input  logic                ex_memWrite,
   input  logic                ex_memToReg,
   input  logic [1:0]          ex_size,
   input  logic                ex_unsigned,
   output logic                stall,
   output logic                dmem_req,
   output logic                dmem_we,
   output logic [DATA_W-1:0]   dmem_addr,
   output logic [DATA_W-1:0]   dmem_wdata,
   output logic [DATA_W/8-1:0] dmem_be,
   input  logic                dmem_ack,
   input  logic [DATA_W-1:0]   dmem_rdata,
   output logic                wb_valid,
   output logic                wb_memToReg,
   output logic [DATA_W-1:0]   wb_readData,
   output logic [DATA_W-1:0]   wb_addr,
   output logic                wb_err
);

   state_e state_q, state_d;

   // Request captured at accept time; held stable for the whole WAIT.
   logic [DATA_W-1:0]   req_addr_q;
   logic [DATA_W-1:0]   req_wdata_q;
   logic [DATA_W/8-1:0] req_be_q;
   logic                req_we_q;
   logic [1:0]          req_size_q;
   logic                req_unsigned_q;
   logic                req_m2r_q;

   logic                wb_valid_q, wb_m2r_q, wb_err_q;
   logic [DATA_W-1:0]   wb_rdata_q, wb_addr_q;

   logic                mem_op, aligned, accept, timeout;
   logic [DATA_W-1:0]   load_data;
   logic [DATA_W-1:0]   store_data;

   assign mem_op  = ex_valid & (ex_memRead | ex_memWrite);
   assign aligned = is_aligned(ex_size, ex_addr[1:0]);
   assign accept  = (state_q == IDLE) & mem_op & aligned;

`ifdef MEM_ACCESS_TIMEOUT_EN
   localparam int unsigned CntW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [CntW-1:0] wait_cnt_q;

   // Ack in the same cycle as the limit wins, so timeout is only acted on without ack.
   assign timeout = (state_q == WAIT) & (wait_cnt_q == CntW'(TIMEOUT_CYCLES - 1));

   // Count WAIT cycles without ack; IDLE keeps it cleared so each WAIT starts at zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt_q <= '0;
      end else if (state_q == IDLE) begin
         wait_cnt_q <= '0;
      end else if (!dmem_ack) begin
         wait_cnt_q <= wait_cnt_q + 1'b1;
      end
   end
`else
   assign timeout = 1'b0;
`endif

   // Replicate store data across lanes so the byte enables alone select the target bytes.
   always_comb begin
      case (ex_size)
         SZ_BYTE: store_data = {4{ex_wdata[7:0]}};
         SZ_HALF: store_data = {2{ex_wdata[15:0]}};
         default: store_data = ex_wdata;
      endcase
   end

   load_align u_load_align (
      .rdata       (dmem_rdata),
      .offset      (req_addr_q[1:0]),
      .size        (req_size_q),
      .is_unsigned (req_unsigned_q),
      .result      (load_data)
   );

   // Next-state and stall decode.
   always_comb begin
      state_d = state_q;
      stall   = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = WAIT;
               stall   = 1'b1;
            end
         end
         WAIT: begin
            if (dmem_ack || timeout) begin
               state_d = IDLE;
            end else begin
               stall = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Capture the request on accept; a store wins over a simultaneous read.
   always_ff @(posedge clk) begin
      if (rst) begin
         req_addr_q     <= '0;
         req_wdata_q    <= '0;
         req_be_q       <= '0;
         req_we_q       <= 1'b0;
         req_size_q     <= 2'b00;
         req_unsigned_q <= 1'b0;
         req_m2r_q      <= 1'b0;
      end else if (accept) begin
         req_addr_q     <= ex_addr;
         req_wdata_q    <= store_data;
         req_be_q       <= byte_en(ex_size, ex_addr[1:0]);
         req_we_q       <= ex_memWrite;
         req_size_q     <= ex_size;
         req_unsigned_q <= ex_unsigned;
         req_m2r_q      <= ex_memToReg & ~ex_memWrite;
      end
   end

   // Write-back bundle: one-cycle valid pulse, data fields hold between pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_valid_q <= 1'b0;
         wb_m2r_q   <= 1'b0;
         wb_err_q   <= 1'b0;
         wb_rdata_q <= '0;
         wb_addr_q  <= '0;
      end else begin
         wb_valid_q <= 1'b0;
         if (state_q == IDLE && ex_valid && !accept) begin
            // Non-memory op passes through; misaligned access reports an error instead.
            wb_valid_q <= 1'b1;
            wb_addr_q  <= ex_addr;
            wb_rdata_q <= '0;
            wb_m2r_q   <= mem_op ? 1'b0 : ex_memToReg;
            wb_err_q   <= mem_op;
         end else if (state_q == WAIT && dmem_ack) begin
            wb_valid_q <= 1'b1;
            wb_addr_q  <= req_addr_q;
            wb_rdata_q <= req_we_q ? '0 : load_data;
            wb_m2r_q   <= req_m2r_q;
            wb_err_q   <= 1'b0;
         end else if (timeout) begin
            wb_valid_q <= 1'b1;
            wb_addr_q  <= req_addr_q;
            wb_rdata_q <= '0;
            wb_m2r_q   <= 1'b0;
            wb_err_q   <= 1'b1;
         end
      end
   end

   assign dmem_req    = (state_q == WAIT);
   assign dmem_we     = req_we_q;
   assign dmem_addr   = {req_addr_q[DATA_W-1:2], 2'b00};
   assign dmem_wdata  = req_wdata_q;
   assign dmem_be     = req_be_q;

   assign wb_valid    = wb_valid_q;
   assign wb_memToReg = wb_m2r_q;
   assign wb_readData = wb_rdata_q;
   assign wb_addr     = wb_addr_q;
   assign wb_err      = wb_err_q;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed cases followed by random transactions
// checked against an arithmetic reference model.
module tb_mem_access;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid, ex_memRead, ex_memWrite, ex_memToReg, ex_unsigned;
   logic [31:0] ex_addr, ex_wdata;
   logic [1:0]  ex_size;
   logic        stall, dmem_req, dmem_we, dmem_ack;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;
   logic        wb_valid, wb_memToReg, wb_err;
   logic [31:0] wb_readData, wb_addr;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   always #5 clk = ~clk;

   mem_access #(
      .DATA_W         (32),
      .TIMEOUT_CYCLES (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .ex_valid    (ex_valid),
      .ex_addr     (ex_addr),
      .ex_wdata    (ex_wdata),
      .ex_memRead  (ex_memRead),
      .ex_memWrite (ex_memWrite),
      .ex_memToReg (ex_memToReg),
      .ex_size     (ex_size),
      .ex_unsigned (ex_unsigned),
      .stall       (stall),
      .dmem_req    (dmem_req),
      .dmem_we     (dmem_we),
      .dmem_addr   (dmem_addr),
      .dmem_wdata  (dmem_wdata),
      .dmem_be     (dmem_be),
      .dmem_ack    (dmem_ack),
      .dmem_rdata  (dmem_rdata),
      .wb_valid    (wb_valid),
      .wb_memToReg (wb_memToReg),
      .wb_readData (wb_readData),
      .wb_addr     (wb_addr),
      .wb_err      (wb_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // ---------------- reference model ----------------
   function automatic logic ref_aligned(input logic [1:0] sz, input logic [31:0] a);
      int unsigned off = a % 4;
      if (sz == 2'd0) return 1'b1;
      if (sz == 2'd1) return (off % 2) == 0;
      return off == 0;
   endfunction

   function automatic logic [31:0] ref_be(input logic [1:0] sz, input logic [31:0] a);
      int unsigned off = a % 4;
      if (sz == 2'd0) return 32'(2 ** off);
      if (sz == 2'd1) return 32'(3 * (2 ** off));
      return 32'd15;
   endfunction

   function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] w);
      longint unsigned v;
      if (sz == 2'd0)      v = longint'(w % 256) * 64'h01010101;
      else if (sz == 2'd1) v = longint'(w % 65536) * 64'h00010001;
      else                 v = longint'(w);
      return v[31:0];
   endfunction

   function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic [31:0] a,
                                            input logic [31:0] rd, input logic uns);
      longint unsigned v;
      int unsigned     off = a % 4;
      longint unsigned sh  = longint'(rd) / (64'd1 << (8 * off));
      if (sz == 2'd0) begin
         v = sh % 256;
         if (!uns && v >= 128) v = v + 64'hFFFFFF00;
      end else if (sz == 2'd1) begin
         v = sh % 65536;
         if (!uns && v >= 32768) v = v + 64'hFFFF0000;
      end else begin
         v = longint'(rd);
      end
      return v[31:0];
   endfunction

   // One complete instruction, entered at posedge+1 with the DUT idle.
   task automatic run_txn(input string tag, input logic valid, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic rd, input logic wr,
                          input logic m2r, input logic [1:0] sz, input logic uns,
                          input logic [31:0] rdata, input int delay);
      logic        mem_op, ok, acc;
      logic [31:0] exp_rd;
      logic        exp_m2r;
      int          stall_cnt;
      ex_valid    = valid;
      ex_addr     = addr;
      ex_wdata    = wdata;
      ex_memRead  = rd;
      ex_memWrite = wr;
      ex_memToReg = m2r;
      ex_size     = sz;
      ex_unsigned = uns;
      dmem_ack    = 1'($urandom_range(0, 1));   // ack while idle must be ignored
      dmem_rdata  = $urandom;
      mem_op      = valid & (rd | wr);
      ok          = ref_aligned(sz, addr);
      acc         = mem_op & ok;
      #4;
      check({tag, " stall_accept"}, 32'(stall), 32'(acc));
      check({tag, " req_idle"}, 32'(dmem_req), 32'd0);
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      if (acc) begin
         stall_cnt = 1;
         check({tag, " req_wait"}, 32'(dmem_req), 32'd1);
         check({tag, " dmem_addr"}, dmem_addr, addr & 32'hFFFF_FFFC);
         check({tag, " dmem_we"}, 32'(dmem_we), 32'(wr));
         if (wr) begin
            check({tag, " dmem_be"}, 32'(dmem_be), ref_be(sz, addr));
            check({tag, " dmem_wdata"}, dmem_wdata, ref_wdata(sz, wdata));
         end
         for (int i = 0; i < delay; i++) begin
            #4;
            if (stall) stall_cnt++;
            check({tag, " req_held"}, 32'(dmem_req), 32'd1);
            @(posedge clk); #1;
         end
         dmem_ack   = 1'b1;
         dmem_rdata = rdata;
         #4;
         check({tag, " stall_ack"}, 32'(stall), 32'd0);
         check({tag, " wb_early"}, 32'(wb_valid), 32'd0);
         @(posedge clk); #1;
         dmem_ack = 1'b0;
         check({tag, " stall_cycles"}, 32'(stall_cnt), 32'(delay + 1));
      end
      ex_valid = 1'b0;
      if (!valid) begin
         check({tag, " wb_valid_none"}, 32'(wb_valid), 32'd0);
      end else begin
         exp_rd  = (acc && !wr) ? ref_load(sz, addr, rdata, uns) : 32'd0;
         exp_m2r = !mem_op ? m2r : (ok && !wr) ? m2r : 1'b0;
         check({tag, " wb_valid"}, 32'(wb_valid), 32'd1);
         check({tag, " wb_err"}, 32'(wb_err), 32'(mem_op & ~ok));
         check({tag, " wb_addr"}, wb_addr, addr);
         check({tag, " wb_readData"}, wb_readData, exp_rd);
         check({tag, " wb_memToReg"}, 32'(wb_memToReg), 32'(exp_m2r));
      end
      @(posedge clk); #1;
      check({tag, " wb_pulse_end"}, 32'(wb_valid), 32'd0);
   endtask

   initial begin
      logic [1:0]  r_sz;
      logic [31:0] r_addr;
      int          req_cycles;
      rst = 1'b1; ex_valid = 0; ex_addr = 0; ex_wdata = 0; ex_memRead = 0; ex_memWrite = 0;
      ex_memToReg = 0; ex_size = 0; ex_unsigned = 0; dmem_ack = 0; dmem_rdata = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #3;
      check("reset stall", 32'(stall), 32'd0);
      check("reset req", 32'(dmem_req), 32'd0);
      check("reset we", 32'(dmem_we), 32'd0);
      check("reset be", 32'(dmem_be), 32'd0);
      check("reset dmem_addr", dmem_addr, 32'd0);
      check("reset wb_valid", 32'(wb_valid), 32'd0);
      check("reset wb_readData", wb_readData, 32'd0);
      check("reset wb_addr", wb_addr, 32'd0);
      check("reset wb_err", 32'(wb_err), 32'd0);
      @(posedge clk); #1;

      // Directed cases from the plan.
      run_txn("lw_0x100", 1, 32'h100, 0, 1, 0, 1, 2'b10, 0, 32'hDEADBEEF, 3);
      run_txn("lb_0x103", 1, 32'h103, 0, 1, 0, 1, 2'b00, 0, 32'h80FF_0000, 0);
      check("lb signed value", wb_readData, 32'hFFFFFF80);
      run_txn("lbu_0x103", 1, 32'h103, 0, 1, 0, 1, 2'b00, 1, 32'h80FF_0000, 1);
      check("lbu value", wb_readData, 32'h00000080);
      run_txn("sh_0x102", 1, 32'h102, 32'h0000ABCD, 0, 1, 1, 2'b01, 0, 0, 2);
      run_txn("lw_mis_0x101", 1, 32'h101, 0, 1, 0, 1, 2'b10, 0, 0, 0);
      run_txn("lh_mis_0x103", 1, 32'h103, 0, 1, 0, 1, 2'b01, 0, 0, 0);
      run_txn("rw_store_wins", 1, 32'h204, 32'h1234_5678, 1, 1, 1, 2'b11, 0, 32'hFFFF_FFFF, 1);
      run_txn("alu_op", 1, 32'hCAFE_0001, 0, 0, 0, 1, 2'b10, 0, 0, 0);

      // Reset while waiting for ack: transaction abandoned, late ack ignored.
      ex_valid = 1; ex_addr = 32'h200; ex_memRead = 1; ex_memWrite = 0; ex_size = 2'b10;
      ex_memToReg = 1;
      @(posedge clk); #1;
      check("rst_wait req_before", 32'(dmem_req), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; ex_valid = 0;
      check("rst_wait req_after", 32'(dmem_req), 32'd0);
      check("rst_wait wb_valid", 32'(wb_valid), 32'd0);
      @(posedge clk); #1;
      dmem_ack = 1'b1; dmem_rdata = 32'h5555_AAAA;
      #4;
      check("rst_wait late_ack stall", 32'(stall), 32'd0);
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      check("rst_wait late_ack wb", 32'(wb_valid), 32'd0);
      check("rst_wait late_ack req", 32'(dmem_req), 32'd0);
      run_txn("lw_after_rst", 1, 32'h208, 0, 1, 0, 1, 2'b10, 0, 32'h0BAD_F00D, 1);

`ifdef MEM_ACCESS_TIMEOUT_EN
      // No ack: the request must be abandoned after four WAIT cycles.
      ex_valid = 1; ex_addr = 32'h300; ex_memRead = 1; ex_memWrite = 0; ex_size = 2'b10;
      @(posedge clk); #1;
      req_cycles = 0;
      for (int i = 0; i < 20; i++) begin
         if (!dmem_req) break;
         req_cycles++;
         @(posedge clk); #1;
      end
      ex_valid = 0;
      check("timeout req_cycles", 32'(req_cycles), 32'd4);
      check("timeout wb_valid", 32'(wb_valid), 32'd1);
      check("timeout wb_err", 32'(wb_err), 32'd1);
      @(posedge clk); #1;
`endif

      // Random transactions.
      for (int n = 0; n < 60; n++) begin
         r_sz   = 2'($urandom_range(0, 3));
         r_addr = $urandom;
         if ($urandom_range(0, 3) != 0) begin
            // Bias towards aligned addresses so most accesses reach memory.
            if (r_sz == 2'd1)      r_addr[0]   = 1'b0;
            else if (r_sz != 2'd0) r_addr[1:0] = 2'b00;
         end
         run_txn($sformatf("rnd%0d", n), 1'($urandom_range(0, 7) != 0), r_addr, $urandom,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 r_sz, 1'($urandom_range(0, 1)), $urandom, int'($urandom_range(0, 3)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
